activation_stream: RTL and testbench
====================================

ACTIVATION_STREAM -- requirements
Module: activation_stream

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14; number of parallel lanes.
REQ-002 SHALL have parameter ACC_WIDTH, default 32; accumulator word width per lane.
REQ-003 SHALL have parameter SHIFT, default 8; fixed-point right shift for rounding in relu, leaky, clamp and passthrough modes.
REQ-004 SHALL have parameter SIG_SHIFT, default 11; right shift producing the sigmoid index in 1/16 units.
REQ-005 SHALL have port clk, input, 1; clock.
REQ-006 SHALL have port rst, input, 1; reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1; input beat valid.
REQ-008 SHALL have port in_ready, output, 1; input beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data, input, MATRIX_WIDTH*ACC_WIDTH; lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-010 SHALL have port in_mode, input, 3; activation code: 0 passthrough, 1 relu, 2 sigmoid, 3 leaky relu, 4 clamp.
REQ-011 SHALL have port in_signed, input, 1; 1 = lanes are two's complement, 0 = unsigned.
REQ-012 SHALL have port in_last, input, 1; end-of-tile marker, carried with the beat.
REQ-013 SHALL have port clamp_ceil, input, 8; clamp-mode ceiling, sampled with the beat.
REQ-014 SHALL have port out_valid, output, 1; output beat valid.
REQ-015 SHALL have port out_ready, input, 1; downstream ready.
REQ-016 SHALL have port out_data, output, MATRIX_WIDTH*8; lane i at bits [i*8 +: 8].
REQ-017 SHALL have port out_last, output, 1; in_last of the emitted beat.
REQ-018 SHALL have port err_mode, output, 1; sticky flag, set on acceptance of a beat with in_mode 5-7.

Function
REQ-019 SHALL implement three register stages: S1 (capture), S2 (rounding), S3 (activation/output). mode, signed, last and ceiling SHALL travel with their beat.
REQ-020 SHALL advance all stages together when adv = !S3.valid || out_ready; in_ready SHALL equal adv.
REQ-021 SHALL, while adv=0, hold every stage register, including out_data and out_last, stable.
REQ-022 SHALL propagate bubbles: stage valid = previous stage valid (S1 takes in_valid) on each adv.
REQ-023 SHALL produce a beat accepted at edge k on out_valid at edge k+2 when unstalled (3-cycle latency); throughput 1 beat/cycle.
REQ-024 SHALL compute rounded r = (acc >> SHIFT) + acc[SHIFT-1], arithmetic shift if signed, logical if unsigned, in ACC_WIDTH-SHIFT+1 bits.
REQ-025 SHALL give sigmoid index s = (acc >> SIG_SHIFT) + acc[SIG_SHIFT-1], with the same signedness rule.
REQ-026 Passthrough SHALL output r saturated: signed to [-128,127], unsigned to [0,255].
REQ-027 relu SHALL output max(r,0) saturated to 127 if signed, 255 if unsigned.
REQ-028 leaky SHALL output r if r>=0, else r>>>3 (arithmetic), saturated to [-128,127]; when unsigned it equals relu.
REQ-029 clamp SHALL output min(max(r,0), clamp_ceil); when signed the ceiling SHALL additionally be limited to 127.
REQ-030 sigmoid unsigned SHALL output min(255, round_half_up(256*sig(s/16))); sigmoid signed SHALL clamp s to [-128,127] and output min(127, round_half_up(128*sig(s/16))). sig(x)=1/(1+e^-x); tables are fixed constants.
REQ-031 Modes 5-7 SHALL output as passthrough and set err_mode; err_mode SHALL clear only on rst.
REQ-032 SHALL compute every lane independently with an identical mode per beat.

Reset
REQ-033 On rst, all stage valids, out_valid, out_last, out_data (0) and err_mode SHALL be 0 at the next edge; in-flight beats are discarded.
REQ-034 in_ready SHALL read 1 during and after reset, since S3 is empty; rst SHALL take priority over acceptance in the same cycle.

Verification
REQ-035 Rounding/relu: unsigned relu, acc=0x00001280 -> 0x13 on out_valid 3 cycles after presentation.
REQ-036 Signed negatives: acc=0xFFFFFB00: relu -> 0x00; leaky -> 0xFF; passthrough -> 0xFB.
REQ-037 Saturation/clamp: acc=0x00FF0000: unsigned relu -> 0xFF; signed relu -> 0x7F; clamp with ceil=6 and acc=0x00001300 -> 0x06.
REQ-038 Sigmoid: acc=0 -> unsigned 128, signed 64; unsigned acc=0x7FFFFFFF -> 255; signed acc=0x80000000 -> 0.
REQ-039 Backpressure: 6 back-to-back beats with out_ready low for cycles 3-6 -> in_ready low while S3 full, all 6 beats delivered in order with correct out_last, no duplicates.
REQ-040 Reset mid-stream plus error: inject mode 6 beat, assert rst with 3 beats in flight -> err_mode=1 before reset, 0 after; no stale beat emitted after reset.

Source files
------------

// File: rtl/activation_stream.sv
// Three-stage activation pipeline: capture, rounding, activation.
// Each lane maps one accumulator word to one 8-bit activation.
module activation_stream #(
   parameter int MATRIX_WIDTH = 14,
   parameter int ACC_WIDTH    = 32,
   parameter int SHIFT        = 8,
   parameter int SIG_SHIFT    = 11
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] in_data,
   input  logic [2:0]                   in_mode,
   input  logic                         in_signed,
   input  logic                         in_last,
   input  logic [7:0]                   clamp_ceil,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [MATRIX_WIDTH*8-1:0]    out_data,
   output logic                         out_last,
   output logic                         err_mode
);

   localparam int MW = MATRIX_WIDTH;
   localparam int AW = ACC_WIDTH;
   localparam int RW = AW - SHIFT + 1;
   localparam int SW = AW - SIG_SHIFT + 1;

   localparam logic [63:0] ONE = 64'h1_0000_0000;

   // e^(-1/16) in Q32, from a short alternating Taylor series
   function automatic logic [63:0] exp_step();
      logic [63:0] term;
      logic [63:0] sum;
      term = ONE;
      sum  = ONE;
      for (int n = 1; n <= 10; n++) begin
         term = term / 64'(16 * n);
         sum  = n[0] ? sum - term : sum + term;
      end
      return sum;
   endfunction

   function automatic logic [1023:0] build_u();
      logic [1023:0] t;
      logic [63:0]   e, p, d, v;
      t = '0;
      e = exp_step();
      p = ONE;
      for (int k = 0; k < 128; k++) begin
         d = ONE + p;
         v = (64'h200_0000_0000 + d) / (d << 1);
         t[k*8 +: 8] = (v > 64'd255) ? 8'hff : v[7:0];
         p = (p * e) >> 32;
      end
      return t;
   endfunction

   // Indexed by the 8-bit two's complement sigmoid index
   function automatic logic [2047:0] build_s();
      logic [2047:0] t;
      logic [63:0]   e, p, d, v;
      t = '0;
      e = exp_step();
      p = ONE;
      for (int k = 0; k <= 128; k++) begin
         d = ONE + p;
         if (k < 128) begin
            v = (64'h100_0000_0000 + d) / (d << 1);
            t[k*8 +: 8] = (v > 64'd127) ? 8'h7f : v[7:0];
         end
         if (k > 0) begin
            v = ((p << 8) + d) / (d << 1);
            t[(256-k)*8 +: 8] = v[7:0];
         end
         p = (p * e) >> 32;
      end
      return t;
   endfunction

   localparam logic [1023:0] SIG_U = build_u();
   localparam logic [2047:0] SIG_S = build_s();

   localparam logic signed [RW:0]   R_ZERO = '0;
   localparam logic signed [RW:0]   R_P127 = (RW+1)'(127);
   localparam logic signed [RW:0]   R_N128 = -(RW+1)'(128);
   localparam logic signed [RW:0]   R_P255 = (RW+1)'(255);
   localparam logic signed [SW-1:0] S_P127 = SW'(127);
   localparam logic signed [SW-1:0] S_N128 = -SW'(128);

   function automatic logic [7:0] sat(input logic signed [RW:0] v,
                                      input logic sgn);
      logic [7:0] o;
      if (sgn) begin
         if (v > R_P127)      o = 8'h7f;
         else if (v < R_N128) o = 8'h80;
         else                 o = v[7:0];
      end else begin
         if (v < R_ZERO)      o = 8'h00;
         else if (v > R_P255) o = 8'hff;
         else                 o = v[7:0];
      end
      return o;
   endfunction

   function automatic logic [7:0] sigm(input logic [SW-1:0] s,
                                       input logic sgn);
      logic signed [SW-1:0] ss;
      logic [7:0]           idx;
      logic [7:0]           o;
      ss = $signed(s);
      if (sgn) begin
         if (ss > S_P127)      idx = 8'h7f;
         else if (ss < S_N128) idx = 8'h80;
         else                  idx = s[7:0];
         o = SIG_S[{idx, 3'b000} +: 8];
      end else begin
         if (s >= SW'(128)) o = 8'hff;
         else               o = SIG_U[{s[6:0], 3'b000} +: 8];
      end
      return o;
   endfunction

   function automatic logic [7:0] act(input logic [RW-1:0] r,
                                      input logic [SW-1:0] s,
                                      input logic [2:0]    mode,
                                      input logic          sgn,
                                      input logic [7:0]    ceil);
      logic signed [RW:0] rx, lk, lim_ext;
      logic [7:0]         lim, res;
      rx = $signed({sgn & r[RW-1], r});
      if (sgn && rx < R_ZERO) lk = rx >>> 3;
      else                    lk = rx;
      lim     = (sgn && ceil > 8'd127) ? 8'd127 : ceil;
      lim_ext = $signed({{(RW-7){1'b0}}, lim});
      res     = sat(rx, sgn);
      unique case (mode)
         3'd1: res = (rx < R_ZERO) ? 8'h00 : sat(rx, sgn);
         3'd2: res = sigm(s, sgn);
         3'd3: begin
            if (sgn) res = sat(lk, 1'b1);
            else     res = sat(rx, 1'b0);
         end
         3'd4: begin
            if (rx < R_ZERO)      res = 8'h00;
            else if (rx > lim_ext) res = lim;
            else                  res = rx[7:0];
         end
         default: res = sat(rx, sgn);
      endcase
      return res;
   endfunction

   logic                  adv;
   logic                  s1_valid, s1_signed, s1_last;
   logic [2:0]            s1_mode;
   logic [7:0]            s1_ceil;
   logic [MW*AW-1:0]      s1_data;
   logic                  s2_valid, s2_signed, s2_last;
   logic [2:0]            s2_mode;
   logic [7:0]            s2_ceil;
   logic [MW-1:0][RW-1:0] s2_r, r_nx;
   logic [MW-1:0][SW-1:0] s2_s, s_nx;
   logic [MW*8-1:0]       act_nx;

   // Reset empties S3, so it counts as an advance cycle
   assign adv      = !out_valid || out_ready || rst;
   assign in_ready = adv;

   for (genvar i = 0; i < MW; i++) begin : g_lane
      logic [AW-1:0] acc;
      logic          sb;
      logic          lsb_unused;
      assign acc        = s1_data[i*AW +: AW];
      assign sb         = s1_signed & acc[AW-1];
      assign r_nx[i]    = {sb, acc[AW-1:SHIFT]} + RW'(acc[SHIFT-1]);
      assign s_nx[i]    = {sb, acc[AW-1:SIG_SHIFT]} + SW'(acc[SIG_SHIFT-1]);
      assign lsb_unused = ^acc[SHIFT-2:0];
   end

   always_comb begin
      act_nx = '0;
      for (int i = 0; i < MW; i++)
         act_nx[i*8 +: 8] = act(s2_r[i], s2_s[i], s2_mode,
                                s2_signed, s2_ceil);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         err_mode  <= 1'b0;
      end else begin
         if (in_valid && adv && in_mode > 3'd4)
            err_mode <= 1'b1;
         if (adv) begin
            s1_valid  <= in_valid;
            s1_data   <= in_data;
            s1_mode   <= in_mode;
            s1_signed <= in_signed;
            s1_last   <= in_last;
            s1_ceil   <= clamp_ceil;
            s2_valid  <= s1_valid;
            s2_r      <= r_nx;
            s2_s      <= s_nx;
            s2_mode   <= s1_mode;
            s2_signed <= s1_signed;
            s2_last   <= s1_last;
            s2_ceil   <= s1_ceil;
            out_valid <= s2_valid;
            out_data  <= act_nx;
            out_last  <= s2_last;
         end
      end
   end

endmodule

// File: tb/tb_activation_stream.sv
// Bench for activation_stream: directed vectors, random stream
// against a real-arithmetic model, backpressure and reset cases.
module tb_activation_stream;

   localparam int MW = 14;
   localparam int AW = 32;
   localparam int SHIFT = 8;
   localparam int SIG_SHIFT = 11;
   localparam int DW = MW * AW;
   localparam int OW = MW * 8;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, in_signed, in_last;
   logic          out_valid, out_ready, out_last, err_mode;
   logic [DW-1:0] in_data;
   logic [2:0]    in_mode;
   logic [7:0]    clamp_ceil;
   logic [OW-1:0] out_data;

   always #5 clk = ~clk;

   activation_stream dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode),
      .in_signed(in_signed), .in_last(in_last),
      .clamp_ceil(clamp_ceil),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .err_mode(err_mode)
   );

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic          o_acc, o_fire, o_valid, o_last, o_ready, o_err;
   logic [OW-1:0] o_data;

   function automatic logic [7:0] model_lane(input logic [31:0] acc,
                                             input logic [2:0] m,
                                             input logic sg,
                                             input logic [7:0] c);
      longint a, r, s, v, hi, lo, cl;
      real    x;
      if (sg) a = longint'($signed(acc));
      else    a = longint'(acc);
      r  = (a >>> SHIFT) + longint'(acc[SHIFT-1]);
      s  = (a >>> SIG_SHIFT) + longint'(acc[SIG_SHIFT-1]);
      hi = sg ? 127 : 255;
      lo = sg ? -128 : 0;
      case (m)
         3'd1: begin
            v = (r < 0) ? 0 : r;
            if (v > hi) v = hi;
         end
         3'd2: begin
            if (sg) begin
               if (s > 127) s = 127;
               if (s < -128) s = -128;
               x = s / 16.0;
               v = longint'($floor(128.0 / (1.0 + $exp(-x)) + 0.5));
               if (v > 127) v = 127;
            end else begin
               x = s / 16.0;
               v = longint'($floor(256.0 / (1.0 + $exp(-x)) + 0.5));
               if (v > 255) v = 255;
            end
         end
         3'd3: begin
            v = (sg && r < 0) ? (r >>> 3) : r;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
         end
         3'd4: begin
            cl = longint'(c);
            if (sg && cl > 127) cl = 127;
            v = (r < 0) ? 0 : r;
            if (v > cl) v = cl;
         end
         default: begin
            v = r;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
         end
      endcase
      return v[7:0];
   endfunction

   function automatic logic [OW-1:0] model_beat(input logic [DW-1:0] d,
                                                input logic [2:0] m,
                                                input logic sg,
                                                input logic [7:0] c);
      logic [OW-1:0] o;
      for (int i = 0; i < MW; i++)
         o[i*8 +: 8] = model_lane(d[i*AW +: AW], m, sg, c);
      return o;
   endfunction

   function automatic logic [31:0] rand_acc();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0: v = v >> $urandom_range(4, 28);
         1: v = 32'($urandom_range(0, 1 << 19)) - 32'(1 << 18);
         2: v = -(v >> $urandom_range(4, 28));
         default: ;
      endcase
      return v;
   endfunction

   // Drive one cycle at negedge, sample pre-edge state, then wait for the edge
   task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic [2:0] m, input logic sg, input logic l,
                       input logic [7:0] c, input logic ordy);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; in_data = d; in_mode = m;
      in_signed = sg; in_last = l; clamp_ceil = c; out_ready = ordy;
      #1;
      o_ready = in_ready;
      o_acc   = v && in_ready && !r;
      o_valid = out_valid;
      o_fire  = out_valid && ordy && !r;
      o_data  = out_data;
      o_last  = out_last;
      o_err   = err_mode;
      if (o_acc) begin
         e.data = model_beat(d, m, sg, c);
         e.last = l;
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      step(1, 0, '0, 0, 0, 0, 0, 1);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b want=1", o_ready);
      end
      step(1, 0, '0, 0, 0, 0, 0, 0);
      step(0, 0, '0, 0, 0, 0, 0, 0);
      checks++;
      if ({o_valid, o_last, o_err, o_ready} !== 4'b0001 || o_data !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%b l=%b e=%b rdy=%b d=%h want 0 0 0 1 0",
                  o_valid, o_last, o_err, o_ready, o_data);
      end
      sb.delete();
   endtask

   logic [31:0] d_acc [11] = '{32'h0000_1280, 32'hFFFF_FB00, 32'hFFFF_FB00,
                               32'hFFFF_FB00, 32'h00FF_0000, 32'h00FF_0000,
                               32'h0000_1300, 32'h0000_0000, 32'h0000_0000,
                               32'h7FFF_FFFF, 32'h8000_0000};
   logic [2:0]  d_mode [11] = '{1, 1, 3, 0, 1, 1, 4, 2, 2, 2, 2};
   logic        d_sg   [11] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
   logic [7:0]  d_ceil [11] = '{0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0};
   logic [7:0]  d_exp  [11] = '{8'h13, 8'h00, 8'hFF, 8'hFB, 8'hFF, 8'h7F,
                               8'h06, 8'd128, 8'd64, 8'd255, 8'd0};

   task automatic test_vectors();
      int  lat;
      bit  got;
      logic [OW-1:0] want;
      for (int i = 0; i < 11; i++) begin
         want = {MW{d_exp[i]}};
         step(0, 1, {MW{d_acc[i]}}, d_mode[i], d_sg[i], i[0], d_ceil[i], 1);
         got = 0;
         lat = 0;
         for (int k = 0; k < 8 && !got; k++) begin
            step(0, 0, '0, 0, 0, 0, 0, 1);
            lat++;
            if (o_fire) begin
               got = 1;
               checks++;
               if (o_data !== want || o_last !== i[0] || lat != 3) begin
                  errors++;
                  $display("FAIL vec%0d got d=%h l=%b lat=%0d want d=%h l=%b lat=3",
                           i, o_data, o_last, lat, want, i[0]);
               end
               void'(sb.pop_front());
            end
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL vec%0d timeout got no beat want d=%h", i, want);
         end
      end
   endtask

   task automatic test_random();
      localparam int N = 300;
      logic [DW-1:0] d;
      logic [2:0]    m;
      logic          sg, l, have, ordy, err_exp;
      logic [7:0]    c;
      int            sent, rcvd;
      exp_t          e;
      sent = 0; rcvd = 0; have = 0; err_exp = 1'b0;
      d = '0; m = 0; sg = 0; l = 0; c = 0;
      for (int cyc = 0; cyc < 5000 && rcvd < N; cyc++) begin
         if (!have && sent < N && $urandom_range(0, 9) < 7) begin
            for (int i = 0; i < MW; i++) d[i*AW +: AW] = rand_acc();
            if ($urandom_range(0, 15) == 0) m = 3'($urandom_range(5, 7));
            else m = 3'($urandom_range(0, 4));
            sg = 1'($urandom);
            l = 1'($urandom);
            c = 8'($urandom);
            have = 1;
         end
         ordy = ($urandom_range(0, 9) < 7);
         step(0, have, d, m, sg, l, c, ordy);
         if (o_acc) begin
            have = 0;
            sent++;
            if (m > 3'd4) err_exp = 1'b1;
         end
         if (o_fire) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rand_extra got d=%h want no beat", o_data);
            end else begin
               e = sb.pop_front();
               if (o_data !== e.data || o_last !== e.last) begin
                  errors++;
                  $display("FAIL rand_beat%0d got d=%h l=%b want d=%h l=%b",
                           rcvd, o_data, o_last, e.data, e.last);
               end
            end
            rcvd++;
         end
      end
      checks++;
      if (rcvd != N) begin
         errors++;
         $display("FAIL rand_count got=%0d want=%0d", rcvd, N);
      end
      step(0, 0, '0, 0, 0, 0, 0, 1);
      checks++;
      if (o_err !== err_exp) begin
         errors++;
         $display("FAIL rand_err got=%b want=%b", o_err, err_exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] bd [6];
      logic [2:0]    bm [6];
      logic          bs [6];
      logic [7:0]    bc [6];
      logic          ordy, prev_stall, prev_last, saw_block;
      logic [OW-1:0] prev_data;
      int            sent, rcvd;
      exp_t          e;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < MW; i++) bd[k][i*AW +: AW] = rand_acc();
         bm[k] = 3'($urandom_range(0, 4));
         bs[k] = 1'($urandom);
         bc[k] = 8'($urandom);
      end
      sb.delete();
      sent = 0; rcvd = 0; prev_stall = 0; saw_block = 0;
      prev_data = '0; prev_last = 0;
      for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
         ordy = !(cyc >= 2 && cyc <= 5);
         if (sent < 6)
            step(0, 1, bd[sent], bm[sent], bs[sent], (sent == 2 || sent == 5),
                 bc[sent], ordy);
         else
            step(0, 0, '0, 0, 0, 0, 0, ordy);
         if (prev_stall) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== prev_data || o_last !== prev_last) begin
               errors++;
               $display("FAIL b2b_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        o_valid, o_data, o_last, prev_data, prev_last);
            end
         end
         if (o_valid && !ordy) begin
            saw_block = 1;
            checks++;
            if (o_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_in_ready got=%b want=0", o_ready);
            end
         end
         prev_stall = o_valid && !ordy;
         prev_data  = o_data;
         prev_last  = o_last;
         if (o_acc) sent++;
         if (o_fire) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra got d=%h want no beat", o_data);
            end else begin
               e = sb.pop_front();
               if (o_data !== e.data || o_last !== e.last) begin
                  errors++;
                  $display("FAIL b2b_beat%0d got d=%h l=%b want d=%h l=%b",
                           rcvd, o_data, o_last, e.data, e.last);
               end
            end
            rcvd++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, '0, 0, 0, 0, 0, 1);
         if (o_fire) rcvd++;
      end
      checks++;
      if (rcvd != 6 || !saw_block) begin
         errors++;
         $display("FAIL b2b_count got=%0d blocked=%b want=6 blocked=1",
                  rcvd, saw_block);
      end
   endtask

   task automatic test_reset_midstream();
      int extra;
      step(1, 0, '0, 0, 0, 0, 0, 1);
      sb.delete();
      step(0, 0, '0, 0, 0, 0, 0, 1);
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_err_clear got=%b want=0", o_err);
      end
      step(0, 1, {MW{32'h0000_1280}}, 3'd6, 0, 1, 0, 0);
      step(0, 1, {MW{32'h0000_2000}}, 3'd1, 0, 0, 0, 0);
      step(0, 1, {MW{32'h0000_3000}}, 3'd0, 1, 1, 0, 0);
      step(0, 0, '0, 0, 0, 0, 0, 0);
      checks++;
      if (o_err !== 1'b1 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_full got e=%b v=%b rdy=%b want e=1 v=1 rdy=0",
                  o_err, o_valid, o_ready);
      end
      step(1, 1, {MW{32'h0000_4000}}, 3'd7, 0, 1, 0, 0);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst_ready got=%b want=1", o_ready);
      end
      sb.delete();
      step(0, 0, '0, 0, 0, 0, 0, 1);
      checks++;
      if ({o_valid, o_last, o_err} !== 3'b000 || o_data !== '0) begin
         errors++;
         $display("FAIL mid_after_rst got v=%b l=%b e=%b d=%h want 0 0 0 0",
                  o_valid, o_last, o_err, o_data);
      end
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         step(0, 0, '0, 0, 0, 0, 0, 1);
         if (o_valid) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL mid_stale got=%0d beats want=0", extra);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
